// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbitration stage.
// Request record and arbitration-policy selectors.
package wb_pkg;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    localparam int WB_PRIO_FIXED = 0;
    localparam int WB_PRIO_RR    = 1;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] waddr;
        logic [WB_DATA_W-1:0] wdata;
    } wb_req_t;
endpackage

// File: rtl/wb_src_fifo.sv
// Per-source request FIFO for the writeback stage.
// Exposes per-slot valid/address so pending writes can be searched.
module wb_src_fifo
    import wb_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [ADDR_W-1:0]         push_waddr,
    input  logic [DATA_W-1:0]         push_wdata,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [ADDR_W-1:0]         head_waddr,
    output logic [DATA_W-1:0]         head_wdata,
    output logic [DEPTH-1:0]          ent_valid,
    output logic [DEPTH*ADDR_W-1:0]   ent_addr
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head_waddr = addr_mem[rd_ptr];
    assign head_wdata = data_mem[rd_ptr];
    assign ent_valid  = vld;

    for (genvar j = 0; j < DEPTH; j++) begin : g_ent
        assign ent_addr[j*ADDR_W +: ADDR_W] = addr_mem[j];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (do_push) begin
                addr_mem[wr_ptr] <= push_waddr;
                data_mem[wr_ptr] <= push_wdata;
                vld[wr_ptr]      <= 1'b1;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_arb_stage.sv
// Writeback stage: merges NUM_SRC request streams into one registered
// register-file write port, with a pending-write lookup for ID.
module wb_arb_stage
    import wb_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int PRIO_MODE  = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_SRC-1:0]               src_valid_i,
    output logic [NUM_SRC-1:0]               src_ready_o,
    input  logic [NUM_SRC-1:0][ADDR_W-1:0]   src_waddr_i,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]   src_wdata_i,
    output logic                             rf_we_o,
    output logic [ADDR_W-1:0]                rf_waddr_o,
    output logic [DATA_W-1:0]                rf_wdata_o,
    output logic [$clog2(NUM_SRC)-1:0]       rf_src_o,
    input  logic [ADDR_W-1:0]                chk_addr_i,
    output logic                             chk_hit_o,
    output logic                             busy_o
);
    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]            full;
    logic [NUM_SRC-1:0]            empty;
    logic [NUM_SRC-1:0]            push;
    logic [NUM_SRC-1:0]            pop;
    logic [ADDR_W-1:0]             head_waddr [NUM_SRC];
    logic [DATA_W-1:0]             head_wdata [NUM_SRC];
    logic [FIFO_DEPTH-1:0]         ent_valid  [NUM_SRC];
    logic [FIFO_DEPTH*ADDR_W-1:0]  ent_addr   [NUM_SRC];
    logic [SRC_W-1:0]              rr_ptr;
    logic [SRC_W-1:0]              rr_next;
    logic                          grant;
    logic [SRC_W-1:0]              grant_idx;
    logic                          hit;

    assign src_ready_o = ~full & {NUM_SRC{~rst_i}};
    assign push        = src_valid_i & src_ready_o;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        wb_src_fifo #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk_i),
            .rst        (rst_i),
            .push       (push[g]),
            .push_waddr (src_waddr_i[g]),
            .push_wdata (src_wdata_i[g]),
            .pop        (pop[g]),
            .full       (full[g]),
            .empty      (empty[g]),
            .head_waddr (head_waddr[g]),
            .head_wdata (head_wdata[g]),
            .ent_valid  (ent_valid[g]),
            .ent_addr   (ent_addr[g])
        );
    end

    // Rotating search; a base of 0 gives plain lowest-index priority.
    always_comb begin
        int base;
        int idx;
        grant     = 1'b0;
        grant_idx = '0;
        pop       = '0;
        idx       = 0;
        base      = (PRIO_MODE == WB_PRIO_RR) ? int'(rr_ptr) : 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = base + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!grant && !empty[idx]) begin
                grant     = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
        if (grant) pop[grant_idx] = 1'b1;
    end

    assign rr_next = (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            rf_src_o   <= '0;
            rr_ptr     <= '0;
        end else begin
            rf_we_o <= grant && (head_waddr[grant_idx] != '0);
            if (grant) begin
                rf_waddr_o <= head_waddr[grant_idx];
                rf_wdata_o <= head_wdata[grant_idx];
                rf_src_o   <= grant_idx;
                rr_ptr     <= rr_next;
            end
        end
    end

    always_comb begin
        hit = rf_we_o && (rf_waddr_o == chk_addr_i);
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                if (ent_valid[i][j] &&
                    ent_addr[i][j*ADDR_W +: ADDR_W] == chk_addr_i) begin
                    hit = 1'b1;
                end
            end
        end
    end

    assign chk_hit_o = hit && (chk_addr_i != '0);
    assign busy_o    = (|(~empty)) | rf_we_o;
endmodule

// File: tb/tb_wb_arb_stage.sv
// Bench for wb_arb_stage: directed vectors plus a randomized run
// compared against per-source queue models for both arbitration modes.
module tb_wb_arb_stage;
    localparam int NS = 2;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int FD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NS-1:0]         valid;
    logic [NS-1:0][AW-1:0] waddr;
    logic [NS-1:0][DW-1:0] wdata;
    logic [AW-1:0]         chk_addr;

    logic [NS-1:0] ready_f, ready_r;
    logic          we_f, we_r;
    logic [AW-1:0] wa_f, wa_r;
    logic [DW-1:0] wd_f, wd_r;
    logic [0:0]    src_f, src_r;
    logic          hit_f, hit_r;
    logic          busy_f, busy_r;

    wb_arb_stage #(
        .NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW),
        .FIFO_DEPTH(FD), .PRIO_MODE(0)
    ) u_fix (
        .clk_i(clk), .rst_i(rst),
        .src_valid_i(valid), .src_ready_o(ready_f),
        .src_waddr_i(waddr), .src_wdata_i(wdata),
        .rf_we_o(we_f), .rf_waddr_o(wa_f), .rf_wdata_o(wd_f),
        .rf_src_o(src_f), .chk_addr_i(chk_addr),
        .chk_hit_o(hit_f), .busy_o(busy_f)
    );

    wb_arb_stage #(
        .NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW),
        .FIFO_DEPTH(FD), .PRIO_MODE(1)
    ) u_rr (
        .clk_i(clk), .rst_i(rst),
        .src_valid_i(valid), .src_ready_o(ready_r),
        .src_waddr_i(waddr), .src_wdata_i(wdata),
        .rf_we_o(we_r), .rf_waddr_o(wa_r), .rf_wdata_o(wd_r),
        .rf_src_o(src_r), .chk_addr_i(chk_addr),
        .chk_hit_o(hit_r), .busy_o(busy_r)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        valid = '0;
        waddr = '0;
        wdata = '0;
    endtask

    typedef struct {
        int            src;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          we;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq [2][NS][$];
    logic          m_we [2];
    logic [AW-1:0] m_wa [2];
    logic [DW-1:0] m_wd [2];
    int            m_src [2];
    int            m_rr [2];

    task automatic rand_run(input int n);
        logic [NS-1:0] e_rdy, a_rdy;
        logic          e_hit, e_busy, a_hit, a_busy, a_we;
        logic [AW-1:0] a_wa;
        logic [DW-1:0] a_wd;
        int            a_src, g, i;
        ent_t          e;
        for (int m = 0; m < 2; m++) begin
            for (int s = 0; s < NS; s++) mq[m][s].delete();
            m_we[m] = 1'b0; m_wa[m] = '0; m_wd[m] = '0;
            m_src[m] = 0; m_rr[m] = 0;
        end
        for (int c = 0; c < n; c++) begin
            for (int s = 0; s < NS; s++) begin
                valid[s] = ($urandom_range(0, 99) < 60);
                waddr[s] = AW'($urandom_range(0, 7));
                wdata[s] = $urandom;
            end
            chk_addr = AW'($urandom_range(0, 7));
            #1;
            for (int m = 0; m < 2; m++) begin
                e_busy = m_we[m];
                e_hit  = m_we[m] && (m_wa[m] == chk_addr);
                for (int s = 0; s < NS; s++) begin
                    e_rdy[s] = (mq[m][s].size() < FD);
                    if (mq[m][s].size() != 0) e_busy = 1'b1;
                    for (int j = 0; j < mq[m][s].size(); j++)
                        if (mq[m][s][j].a == chk_addr) e_hit = 1'b1;
                end
                if (chk_addr == '0) e_hit = 1'b0;
                a_rdy  = (m == 0) ? ready_f : ready_r;
                a_hit  = (m == 0) ? hit_f : hit_r;
                a_busy = (m == 0) ? busy_f : busy_r;
                a_we   = (m == 0) ? we_f : we_r;
                a_wa   = (m == 0) ? wa_f : wa_r;
                a_wd   = (m == 0) ? wd_f : wd_r;
                a_src  = (m == 0) ? int'(src_f) : int'(src_r);
                check($sformatf("rnd%0d ready", m), 64'(a_rdy), 64'(e_rdy));
                check($sformatf("rnd%0d hit", m), 64'(a_hit), 64'(e_hit));
                check($sformatf("rnd%0d busy", m), 64'(a_busy), 64'(e_busy));
                check($sformatf("rnd%0d we", m), 64'(a_we), 64'(m_we[m]));
                check($sformatf("rnd%0d waddr", m), 64'(a_wa), 64'(m_wa[m]));
                check($sformatf("rnd%0d wdata", m), 64'(a_wd), 64'(m_wd[m]));
                check($sformatf("rnd%0d src", m), 64'(a_src), 64'(m_src[m]));
                g = -1;
                for (int k = 0; k < NS; k++) begin
                    i = (m == 0) ? k : (m_rr[m] + k) % NS;
                    if (g < 0 && mq[m][i].size() != 0) g = i;
                end
                if (g >= 0) begin
                    e = mq[m][g].pop_front();
                    m_we[m]  = (e.a != '0);
                    m_wa[m]  = e.a;
                    m_wd[m]  = e.d;
                    m_src[m] = g;
                    m_rr[m]  = (g + 1) % NS;
                end else begin
                    m_we[m] = 1'b0;
                end
                for (int s = 0; s < NS; s++)
                    if (valid[s] && e_rdy[s])
                        mq[m][s].push_back('{a: waddr[s], d: wdata[s]});
            end
            step();
        end
        idle_in();
    endtask

    vec_t tbl [4];

    initial begin
        tbl[0] = '{0, 5'd5,  32'hDEADBEEF, 1'b1};
        tbl[1] = '{1, 5'd9,  32'h00001234, 1'b1};
        tbl[2] = '{0, 5'd0,  32'h00000055, 1'b0};
        tbl[3] = '{1, 5'd31, 32'hFFFFFFFF, 1'b1};

        idle_in();
        chk_addr = '0;
        rst = 1'b1;
        step();
        step();
        check("rst we", 64'(we_f), 64'(0));
        check("rst waddr", 64'(wa_f), 64'(0));
        check("rst wdata", 64'(wd_f), 64'(0));
        check("rst src", 64'(src_f), 64'(0));
        check("rst ready fix", 64'(ready_f), 64'(0));
        check("rst ready rr", 64'(ready_r), 64'(0));
        check("rst busy", 64'(busy_f), 64'(0));
        rst = 1'b0;
        #1;
        check("rel ready fix", 64'(ready_f), 64'(2'b11));
        check("rel ready rr", 64'(ready_r), 64'(2'b11));

        for (int t = 0; t < 4; t++) begin
            valid[tbl[t].src] = 1'b1;
            waddr[tbl[t].src] = tbl[t].a;
            wdata[tbl[t].src] = tbl[t].d;
            step();
            idle_in();
            check($sformatf("tbl%0d busy T", t), 64'(busy_f), 64'(1));
            check($sformatf("tbl%0d we T", t), 64'(we_f), 64'(0));
            step();
            check($sformatf("tbl%0d we", t), 64'(we_f), 64'(tbl[t].we));
            check($sformatf("tbl%0d waddr", t), 64'(wa_f), 64'(tbl[t].a));
            check($sformatf("tbl%0d wdata", t), 64'(wd_f), 64'(tbl[t].d));
            check($sformatf("tbl%0d src", t), 64'(src_f), 64'(tbl[t].src));
            step();
            check($sformatf("tbl%0d we off", t), 64'(we_f), 64'(0));
            check($sformatf("tbl%0d busy off", t), 64'(busy_f), 64'(0));
        end

        valid = 2'b11;
        waddr[0] = 5'd3; wdata[0] = 32'h11;
        waddr[1] = 5'd4; wdata[1] = 32'h22;
        step();
        idle_in();
        step();
        check("pair1 we", 64'(we_f), 64'(1));
        check("pair1 waddr", 64'(wa_f), 64'(3));
        check("pair1 wdata", 64'(wd_f), 64'(32'h11));
        check("pair1 src", 64'(src_f), 64'(0));
        step();
        check("pair2 we", 64'(we_f), 64'(1));
        check("pair2 waddr", 64'(wa_f), 64'(4));
        check("pair2 wdata", 64'(wd_f), 64'(32'h22));
        check("pair2 src", 64'(src_f), 64'(1));
        step();
        check("pair done", 64'(we_f), 64'(0));

        rst = 1'b1;
        step();
        rst = 1'b0;
        valid = 2'b11;
        waddr[0] = 5'd1; wdata[0] = 32'hA0;
        waddr[1] = 5'd2; wdata[1] = 32'hB0;
        step();
        check("cont rdy1 first", 64'(ready_f[1]), 64'(1));
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("cont%0d fix rdy1", k), 64'(ready_f[1]), 64'(0));
            check($sformatf("cont%0d fix rdy0", k), 64'(ready_f[0]), 64'(1));
            check($sformatf("cont%0d fix src", k), 64'(src_f), 64'(0));
            check($sformatf("cont%0d rr src", k), 64'(src_r), 64'(k % 2));
            check($sformatf("cont%0d rr we", k), 64'(we_r), 64'(1));
        end
        idle_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("cont rst busy", 64'(busy_f), 64'(0));
        check("cont rst we", 64'(we_f), 64'(0));
        check("cont rst busy rr", 64'(busy_r), 64'(0));

        valid[1] = 1'b1;
        waddr[1] = 5'd7;
        wdata[1] = 32'h77;
        chk_addr = 5'd7;
        step();
        idle_in();
        #1;
        check("chk queued", 64'(hit_f), 64'(1));
        chk_addr = 5'd6;
        #1;
        check("chk other", 64'(hit_f), 64'(0));
        chk_addr = 5'd7;
        step();
        check("chk out we", 64'(we_f), 64'(1));
        check("chk out waddr", 64'(wa_f), 64'(7));
        check("chk at port", 64'(hit_f), 64'(1));
        step();
        check("chk retired", 64'(hit_f), 64'(0));

        valid = 2'b11;
        waddr[0] = 5'd1; wdata[0] = 32'h1;
        waddr[1] = 5'd7; wdata[1] = 32'h77;
        step();
        valid = 2'b01;
        #1;
        check("mid hit0", 64'(hit_f), 64'(1));
        step();
        check("mid hit1", 64'(hit_f), 64'(1));
        step();
        check("mid hit2", 64'(hit_f), 64'(1));
        check("mid src", 64'(src_f), 64'(0));
        rst = 1'b1;
        idle_in();
        step();
        check("mid rst hit", 64'(hit_f), 64'(0));
        check("mid rst we", 64'(we_f), 64'(0));
        check("mid rst busy", 64'(busy_f), 64'(0));
        check("mid rst ready", 64'(ready_f), 64'(0));
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("mid post%0d we", k), 64'(we_f), 64'(0));
            check($sformatf("mid post%0d busy", k), 64'(busy_f), 64'(0));
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        rand_run(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
